// File: rtl/miner_pkg.sv
// Shared definitions for the miner datapath: byte width, serializer FSM states,
// and the width helper for byte counters.
package miner_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    // Bits needed to hold a byte count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Breaks one wide word into a byte stream for the UART transmitter.
// A word is taken in IDLE; SEND presents one byte per downstream handshake.
module word_serializer
    import miner_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_WIDTH-1:0]                         d,
    input  logic                                          flush,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [BYTE_W-1:0]                             out_data,
    output logic [cnt_width(DATA_WIDTH/BYTE_W)-1:0]       bytes_left,
    output logic                                          done
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
    localparam int CW        = cnt_width(NUM_BYTES);

    // Handshake rule for both sides: a transfer happens only in a cycle where
    // valid and ready are both high; valid never depends on ready.

    ser_state_t              r_state;
    ser_state_t              w_state_next;
    logic [DATA_WIDTH-1:0]   r_sreg;
    logic [CW-1:0]           r_cnt;
    logic                    r_done;
    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_last;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready && w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (flush) w_state_next = IDLE;
    end

    assign w_accept = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;
    assign w_last   = (r_cnt == CW'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // Flush wins over both acceptance and a concurrent byte handshake.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (flush) begin
            r_sreg <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_accept) begin
            r_sreg <= d;
            r_cnt  <= CW'(NUM_BYTES);
            r_done <= 1'b0;
        end else if (w_out_hs) begin
            if (LSB_FIRST) r_sreg <= r_sreg >> BYTE_W;
            else           r_sreg <= r_sreg << BYTE_W;
            r_cnt  <= r_cnt - CW'(1);
            r_done <= w_last;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign out_data   = LSB_FIRST ? r_sreg[BYTE_W-1:0] : r_sreg[DATA_WIDTH-1 -: BYTE_W];
    assign bytes_left = r_cnt;
    assign done       = r_done;

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Transmit-side counterpart of the byte-packing shift register in the miner datapath.
- Accepts one wide word (nonce, hash fragment or status) from the mining core and emits it as a stream of bytes toward the UART transmitter.
- Upstream interface: valid/ready. Downstream interface: valid/ready, one byte per handshake, MSB byte first by default.

Parameters:
- DATA_WIDTH, 32, width of input word; must be a multiple of 8 and at least 16.
- LSB_FIRST, 0, 0 = most-significant byte first, 1 = least-significant byte first.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset_n  input  1  reset, asynchronous, active-low; clears all state.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- d  input  DATA_WIDTH  word to serialize; sampled on in_valid && in_ready.
- flush  input  1  synchronous abort; discards the remaining bytes.
- out_valid  output  1  out_data holds a byte for the UART TX.
- out_ready  input  1  UART TX consumes the byte this cycle.
- out_data  output  8  current byte.
- bytes_left  output  clog2(DATA_WIDTH/8)+1  bytes not yet handshaken, including the current byte.
- done  output  1  one-cycle pulse after the last byte handshake.

Behaviour:
- NUM_BYTES = DATA_WIDTH/8. Internal state: shift register sreg[DATA_WIDTH-1:0], counter cnt, two-state FSM (IDLE, SEND).
- Reset (reset_n=0, asynchronous):
  - state = IDLE; sreg, cnt, done, out_data = 0.
  - Outputs while held in reset: in_ready=1, out_valid=0, bytes_left=0.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: sreg<=d, cnt<=NUM_BYTES, state<=SEND.
  - First byte is valid on the cycle after acceptance (latency 1).
- SEND:
  - in_ready=0; in_valid is ignored and d is not sampled.
  - out_valid=1.
  - out_data = sreg[DATA_WIDTH-1:DATA_WIDTH-8] when LSB_FIRST=0; sreg[7:0] when LSB_FIRST=1.
  - Handshake (out_valid && out_ready):
    - LSB_FIRST=0: sreg<=sreg<<8, zero-fill.
    - LSB_FIRST=1: sreg<=sreg>>8, zero-fill.
    - cnt<=cnt-1.
    - If cnt==1: state<=IDLE, done<=1 on the next cycle.
  - Backpressure: while out_ready=0, out_data, bytes_left and sreg hold stable.
- bytes_left = cnt; it reads 0 in IDLE.
- Throughput with out_ready tied high: NUM_BYTES byte cycles plus 1 idle cycle per word. in_ready rises in the cycle done pulses, so the next word can be accepted then.
- done:
  - Registered; high exactly one cycle.
  - Never asserted on flush or reset.
- flush (synchronous, highest priority after reset):
  - In any state: state<=IDLE, cnt<=0, sreg<=0.
  - A concurrent out handshake in that cycle still counts as consumed by downstream, but done is not raised.
  - flush together with in_valid in IDLE: the word is dropped.
- Reset mid-word: all remaining bytes are lost; no done pulse.
- Width rule: cnt never underflows; a handshake is impossible when cnt==0 because out_valid=0.

Decomposition:
- Shared package miner_pkg:
  - BYTE_W=8.
  - Enumerated FSM state type ser_state_t {IDLE, SEND}.
  - Function for the bytes_left width: clog2(n)+1.
- No sub-module. Single flat module: FSM, down-counter and shift register.

Test Plan:
- Basic order: DATA_WIDTH=32, LSB_FIRST=0, d=0xDEADBEEF accepted, out_ready=1 -> out_data DE,AD,BE,EF on four consecutive cycles, starting the cycle after acceptance; bytes_left 4,3,2,1; done pulses one cycle after EF; in_ready back to 1 in that cycle.
- Byte order flip: LSB_FIRST=1, d=0x01020304 -> out_data 04,03,02,01.
- Backpressure: out_ready toggled 1,0,0,1,1,0,1 with d=0xA1B2C3D4 -> out_data held stable across stalls; exactly 4 handshakes (A1,B2,C3,D4); done once.
- Busy-ignore: second in_valid with d=0x11111111 while in SEND -> in_ready=0; emitted bytes remain those of the first word; the second word is accepted only once in_ready returns to 1.
- Flush: after 2 bytes of 0xCAFEBABE, pulse flush -> next cycle out_valid=0, bytes_left=0, no done; a new word 0x00000055 then yields 00,00,00,55.
- Async reset: drop reset_n mid-clock during byte 3 of 0x12345678 -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; no done; after release a new word serializes normally.
